// File: rtl/bsa_pkg.sv
// Shared types and default widths for the bit stream aligner.
package bsa_pkg;

  // Default geometry: 128-bit input words, 256-bit window, up to 64 bits consumed per cycle.
  localparam int unsigned DEF_IN_W     = 128;
  localparam int unsigned DEF_WIN_W    = 256;
  localparam int unsigned DEF_MAX_TAKE = 64;

  // Stream phases: IDLE waits for the first word, RUN streams, DRAIN empties the buffer after
  // the last word, DONE is the single completion cycle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } bsa_state_t;

endpackage

// File: rtl/bsa_shifter.sv
// Logarithmic barrel shifter with zero fill. One stage per amount bit; stage k shifts by 2**k.
// LEFT selects the direction (1: towards the MSB, 0: towards the LSB).
module bsa_shifter #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned AMT_W = 8,
  parameter bit          LEFT  = 1'b0
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] stage_val;

  // Apply each power-of-two stage in turn; stages wider than WIDTH flush to zero.
  always_comb begin
    stage_val = data;
    for (int k = 0; k < int'(AMT_W); k++) begin
      if (amt[k]) begin
        if (LEFT) begin
          stage_val = stage_val << (1 << k);
        end else begin
          stage_val = stage_val >> (1 << k);
        end
      end
    end
  end

  assign result = stage_val;

endmodule

// File: rtl/bit_stream_aligner.sv
// Bit stream aligner: packs fixed-width input words into an LSB-aligned bit buffer and lets a
// consumer remove a variable number of bits per cycle from the oldest end.
// Optional feature: define BSA_STATS_EN to add the o_bits_taken / o_stall_cycles counters.
module bit_stream_aligner
  import bsa_pkg::*;
#(
  parameter int unsigned IN_W     = DEF_IN_W,
  parameter int unsigned WIN_W    = DEF_WIN_W,      // must be >= 2*IN_W
  parameter int unsigned MAX_TAKE = DEF_MAX_TAKE,   // must be <= IN_W
  parameter int unsigned LVL_W    = $clog2(WIN_W + 1),
  parameter int unsigned TAKE_W   = $clog2(MAX_TAKE + 1)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [IN_W-1:0]     i_in_word,
  input  logic                i_in_last,
  output logic [MAX_TAKE-1:0] o_win,
  output logic [TAKE_W-1:0]   o_win_bits,
  output logic                o_win_valid,
  input  logic                i_take_valid,
  input  logic [TAKE_W-1:0]   i_take_len,
  output logic                o_done,
`ifdef BSA_STATS_EN
  output logic [31:0]         o_bits_taken,
  output logic [31:0]         o_stall_cycles,
`endif
  output logic                o_err
);

  localparam logic [LVL_W-1:0]  IN_LVL   = LVL_W'(IN_W);
  localparam logic [LVL_W-1:0]  RDY_MAX  = LVL_W'(WIN_W - IN_W);
  localparam logic [LVL_W-1:0]  TAKE_LVL = LVL_W'(MAX_TAKE);
  localparam logic [TAKE_W-1:0] TAKE_MAX = TAKE_W'(MAX_TAKE);

  bsa_state_t       state_q;
  logic [WIN_W-1:0] bit_buf_q;
  logic [LVL_W-1:0] level_q;
  logic             done_q;
  logic             err_q;

  logic              accept;
  logic              take_ok;
  logic              take_bad;
  logic [TAKE_W-1:0] take_amt;
  logic [LVL_W-1:0]  ins_amt;
  logic [WIN_W-1:0]  word_ext;
  logic [WIN_W-1:0]  buf_shr;
  logic [WIN_W-1:0]  word_shl;
  logic [WIN_W-1:0]  buf_nxt;
  logic [LVL_W-1:0]  level_nxt;

  // Consumer-facing view, derived purely from registered state.
  always_comb begin
    o_win       = bit_buf_q[MAX_TAKE-1:0];
    o_win_bits  = (level_q >= TAKE_LVL) ? TAKE_MAX : level_q[TAKE_W-1:0];
    o_win_valid = 1'b0;
    case (state_q)
      // While streaming, only offer full windows so a take never starves mid-stream.
      StRun:   o_win_valid = (level_q >= TAKE_LVL);
      StDrain: o_win_valid = (level_q != '0);
      default: o_win_valid = 1'b0;
    endcase
  end

  // Room for a whole word is required; never looks at the take port.
  always_comb begin
    o_in_ready = ((state_q == StIdle) || (state_q == StRun)) && (level_q <= RDY_MAX);
  end

  // Handshake decode: illegal takes are dropped and only flag an error.
  always_comb begin
    accept   = i_in_valid && o_in_ready;
    take_ok  = i_take_valid && o_win_valid && (i_take_len <= o_win_bits);
    take_bad = i_take_valid && !take_ok;
    take_amt = take_ok ? i_take_len : '0;
    // New word lands just above the bits that survive this cycle's take.
    ins_amt  = level_q - LVL_W'(take_amt);
    word_ext = {{(WIN_W - IN_W){1'b0}}, i_in_word};
  end

  bsa_shifter #(
    .WIDTH (WIN_W),
    .AMT_W (TAKE_W),
    .LEFT  (1'b0)
  ) u_consume_shr (
    .data   (bit_buf_q),
    .amt    (take_amt),
    .result (buf_shr)
  );

  bsa_shifter #(
    .WIDTH (WIN_W),
    .AMT_W (LVL_W),
    .LEFT  (1'b1)
  ) u_insert_shl (
    .data   (word_ext),
    .amt    (ins_amt),
    .result (word_shl)
  );

  // Buffer and level update; bits above the level stay zero because both shifters zero-fill.
  always_comb begin
    buf_nxt   = buf_shr | (accept ? word_shl : '0);
    level_nxt = level_q - LVL_W'(take_amt) + (accept ? IN_LVL : '0);
  end

  // Stream FSM with registered done pulse, sticky error and the bit buffer itself.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      bit_buf_q <= '0;
      level_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bit_buf_q <= buf_nxt;
      level_q   <= level_nxt;
      done_q    <= 1'b0;
      if (take_bad) begin
        err_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= i_in_last ? StDrain : StRun;
          end
        end
        StRun: begin
          if (accept && i_in_last) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (level_nxt == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_done = done_q;
  assign o_err  = err_q;

`ifdef BSA_STATS_EN
  logic [31:0] bits_taken_q;
  logic [31:0] stall_cycles_q;

  // Free-running statistics; both wrap naturally at 2**32.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bits_taken_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      bits_taken_q <= bits_taken_q + 32'(take_amt);
      if (i_in_valid && !o_in_ready) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign o_bits_taken   = bits_taken_q;
  assign o_stall_cycles = stall_cycles_q;
`endif

  // The buffer can never hold more than its capacity.
  level_bound_a: assert property (@(posedge i_clk) disable iff (i_reset)
    level_q <= LVL_W'(WIN_W));

  // Completion is a single-cycle pulse.
  done_pulse_a: assert property (@(posedge i_clk) disable iff (i_reset)
    o_done |=> !o_done);

endmodule
